// File: rtl/evm_ballot_controller.sv
// Voting-session sequencer for the EVM: opens/closes the poll, arms one ballot per officer
// authorisation, captures a single candidate press per ballot and keeps saturating tallies.
//
// state   | meaning
// CLOSED  | poll not open, waiting for session_start
// IDLE    | poll open, waiting for officer to authorise a ballot
// ARMED   | ballot lamp lit, waiting for exactly one candidate button
// ACK     | vote counted this cycle, vote_ack asserted
// LOCKOUT | minimum gap before the next ballot, also waits for buttons to release
// RESULT  | poll closed, tallies frozen and final
module evm_ballot_controller #(
    parameter int CNT_W          = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             session_start,
    input  logic             session_close,
    input  logic             voter_enable,
    input  logic [3:0]       button,
    output logic             ballot_ready,
    output logic             vote_ack,
    output logic             multi_press,
    output logic             overflow,
    output logic             result_valid,
    output logic [CNT_W-1:0] vote_count_c1,
    output logic [CNT_W-1:0] vote_count_c2,
    output logic [CNT_W-1:0] vote_count_c3,
    output logic [CNT_W-1:0] vote_count_c4
);

    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        IDLE    = 3'd1,
        ARMED   = 3'd2,
        ACK     = 3'd3,
        LOCKOUT = 3'd4,
        RESULT  = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [LK_W-1:0]  lock_cnt;
    logic [CNT_W-1:0] tally [4];
    logic [3:0]       inc;
    logic             lock_load;
    logic             multi;
    logic             clear;
    logic             one_hot;

    assign one_hot = (button != 4'b0000) && ((button & (button - 4'd1)) == 4'b0000);

    always_comb begin
        state_next = state;
        inc        = 4'b0000;
        lock_load  = 1'b0;
        multi      = 1'b0;
        clear      = 1'b0;
        case (state)
            CLOSED: begin
                if (session_start) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end
            end
            IDLE: begin
                if (session_close)
                    state_next = RESULT;
                else if (voter_enable && button == 4'b0000)
                    state_next = ARMED;
            end
            ARMED: begin
                // close wins over a simultaneous press: the ballot is abandoned uncounted
                if (session_close)
                    state_next = RESULT;
                else if (one_hot) begin
                    state_next = ACK;
                    inc        = button;
                end else if (button != 4'b0000)
                    multi = 1'b1;
            end
            ACK: begin
                if (session_close)
                    state_next = RESULT;
                else begin
                    state_next = LOCKOUT;
                    lock_load  = 1'b1;
                end
            end
            LOCKOUT: begin
                if (session_close)
                    state_next = RESULT;
                else if (lock_cnt == '0 && button == 4'b0000)
                    state_next = IDLE;
            end
            RESULT: begin
                if (session_start) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end
            end
            default: state_next = CLOSED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= CLOSED;
            lock_cnt     <= '0;
            overflow     <= 1'b0;
            ballot_ready <= 1'b0;
            vote_ack     <= 1'b0;
            multi_press  <= 1'b0;
            result_valid <= 1'b0;
            for (int i = 0; i < 4; i++) tally[i] <= '0;
        end else begin
            state        <= state_next;
            ballot_ready <= (state_next == ARMED);
            vote_ack     <= (state_next == ACK);
            result_valid <= (state_next == RESULT);
            multi_press  <= multi;

            if (lock_load)
                lock_cnt <= LK_LOAD;
            else if (state == LOCKOUT && lock_cnt != '0)
                lock_cnt <= lock_cnt - 1'b1;

            if (clear) begin
                overflow <= 1'b0;
                for (int i = 0; i < 4; i++) tally[i] <= '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (inc[i]) begin
                        if (tally[i] == CNT_MAX)
                            overflow <= 1'b1;
                        else
                            tally[i] <= tally[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign vote_count_c1 = tally[0];
    assign vote_count_c2 = tally[1];
    assign vote_count_c3 = tally[2];
    assign vote_count_c4 = tally[3];

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Directed bench for evm_ballot_controller: session flow, multi-press, stuck button,
// saturation and mid-ballot reset, all against hand-computed values.
module tb_evm_ballot_controller;

    localparam int CNT_W = 8;
    localparam int LK    = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             session_start, session_close, voter_enable;
    logic [3:0]       button;
    logic             ballot_ready, vote_ack, multi_press, overflow, result_valid;
    logic [CNT_W-1:0] vote_count_c1, vote_count_c2, vote_count_c3, vote_count_c4;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_ack  = 0;
    int n_mp   = 0;

    evm_ballot_controller #(.CNT_W(CNT_W), .LOCKOUT_CYCLES(LK)) dut (
        .clock         (clock),
        .reset         (reset),
        .session_start (session_start),
        .session_close (session_close),
        .voter_enable  (voter_enable),
        .button        (button),
        .ballot_ready  (ballot_ready),
        .vote_ack      (vote_ack),
        .multi_press   (multi_press),
        .overflow      (overflow),
        .result_valid  (result_valid),
        .vote_count_c1 (vote_count_c1),
        .vote_count_c2 (vote_count_c2),
        .vote_count_c3 (vote_count_c3),
        .vote_count_c4 (vote_count_c4)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock; outputs sampled 1 time unit after the edge, pulses tallied here
    task automatic tick();
        @(posedge clock);
        #1;
        if (vote_ack) n_ack++;
        if (multi_press) n_mp++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // IDLE -> ARMED -> ACK, then release and sit out the lockout back to IDLE
    task automatic cast_vote(input logic [3:0] btn);
        voter_enable = 1'b1;
        button       = 4'b0000;
        tick();
        voter_enable = 1'b0;
        button       = btn;
        tick();
        button = 4'b0000;
        ticks(LK + 2);
    endtask

    task automatic pulse_start();
        session_start = 1'b1;
        tick();
        session_start = 1'b0;
    endtask

    task automatic pulse_close();
        session_close = 1'b1;
        tick();
        session_close = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        session_start = 1'b0;
        session_close = 1'b0;
        voter_enable  = 1'b0;
        button        = 4'b0000;
        ticks(2);
        check("rst_ready", ballot_ready, 0);
        check("rst_result", result_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_c1", vote_count_c1, 0);
        reset = 1'b1;
        tick();

        // voter_enable while CLOSED must not arm
        voter_enable = 1'b1;
        tick();
        voter_enable = 1'b0;
        check("closed_no_arm", ballot_ready, 0);

        // 1: three votes for c1, then close
        pulse_start();
        n_ack = 0;
        for (int v = 0; v < 3; v++) cast_vote(4'b0001);
        check("t1_c1", vote_count_c1, 3);
        check("t1_c2", vote_count_c2, 0);
        check("t1_c3", vote_count_c3, 0);
        check("t1_c4", vote_count_c4, 0);
        check("t1_acks", n_ack, 3);
        pulse_close();
        check("t1_result", result_valid, 1);
        voter_enable = 1'b1;
        button = 4'b0001;
        ticks(3);
        voter_enable = 1'b0;
        button = 4'b0000;
        check("t1_frozen_c1", vote_count_c1, 3);
        check("t1_result_hold", result_valid, 1);
        check("t1_no_arm", ballot_ready, 0);

        // 2: multi-press then valid press
        pulse_start();
        check("t2_cleared", vote_count_c1, 0);
        check("t2_result_off", result_valid, 0);
        n_ack = 0;
        n_mp  = 0;
        voter_enable = 1'b1;
        tick();
        voter_enable = 1'b0;
        check("t2_armed", ballot_ready, 1);
        button = 4'b0110;
        tick();
        check("t2_mp_pulse", multi_press, 1);
        check("t2_still_armed", ballot_ready, 1);
        button = 4'b0000;
        tick();
        check("t2_mp_low", multi_press, 0);
        check("t2_mp_count", n_mp, 1);
        check("t2_no_c2", vote_count_c2, 0);
        check("t2_no_c3", vote_count_c3, 0);
        button = 4'b0100;
        tick();
        check("t2_ack", vote_ack, 1);
        check("t2_c3", vote_count_c3, 1);
        check("t2_ready_off", ballot_ready, 0);
        button = 4'b0000;
        tick();
        check("t2_ack_pulse", vote_ack, 0);
        ticks(LK + 2);

        // 3: stuck button after the vote, enable during lockout is discarded
        n_ack = 0;
        voter_enable = 1'b1;
        tick();
        voter_enable = 1'b0;
        button = 4'b1000;
        tick();
        for (int i = 0; i < 40; i++) begin
            voter_enable = (i % 5 == 0);
            tick();
        end
        voter_enable = 1'b0;
        check("t3_c4", vote_count_c4, 1);
        check("t3_acks", n_ack, 1);
        check("t3_not_armed", ballot_ready, 0);
        button = 4'b0000;
        tick();
        check("t3_enable_dropped", ballot_ready, 0);
        voter_enable = 1'b1;
        tick();
        voter_enable = 1'b0;
        check("t3_rearm", ballot_ready, 1);

        // 5: close wins over a press in the same cycle
        session_close = 1'b1;
        button = 4'b0001;
        tick();
        session_close = 1'b0;
        button = 4'b0000;
        check("t5_result", result_valid, 1);
        check("t5_ready_off", ballot_ready, 0);
        check("t5_no_ack", vote_ack, 0);
        check("t5_c1", vote_count_c1, 0);

        // 4: saturate c2
        pulse_start();
        for (int v = 0; v < 255; v++) cast_vote(4'b0010);
        check("t4_c2_max", vote_count_c2, 255);
        check("t4_no_ovf", overflow, 0);
        cast_vote(4'b0010);
        check("t4_c2_sat", vote_count_c2, 255);
        check("t4_ovf", overflow, 1);
        pulse_close();
        check("t4_ovf_sticky", overflow, 1);
        pulse_start();
        check("t4_clr_c2", vote_count_c2, 0);
        check("t4_clr_ovf", overflow, 0);

        // 6: reset while a ballot is armed
        for (int v = 0; v < 5; v++) cast_vote(4'b0100);
        check("t6_c3", vote_count_c3, 5);
        voter_enable = 1'b1;
        tick();
        voter_enable = 1'b0;
        check("t6_armed", ballot_ready, 1);
        reset = 1'b0;
        tick();
        check("t6_ready_off", ballot_ready, 0);
        check("t6_c3_zero", vote_count_c3, 0);
        reset = 1'b1;
        button = 4'b0001;
        tick();
        button = 4'b0000;
        voter_enable = 1'b1;
        tick();
        voter_enable = 1'b0;
        check("t6_closed", ballot_ready, 0);
        check("t6_c1_zero", vote_count_c1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
